// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
//   state_t     : arbiter FSM states
//   LEN_*       : access length codes, same encoding as the memory-access unit
//   mem_xact_t  : latched request bundle {we, addr, wdata, len} at the default width
package mem_arbiter_pkg;

  localparam int MEM_AW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] wdata;
    logic [1:0]        len;
  } mem_xact_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory port plus the fetch starvation counter.
//   arb_en   : arbitration happens this cycle (FSM idle)
//   fu_req   : raw fetch request
//   fu_block : fetch may not win this cycle (flush)
//   mau_req  : data request
//   fu_win / mau_win : one-hot winner, both 0 when nothing is granted
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic fu_req,
  input  logic fu_block,
  input  logic mau_req,
  output logic fu_win,
  output logic mau_win
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  always_comb begin
    starved      = (starve_cnt_q == SW'(STARVE_MAX));
    // Data has priority unless fetch has lost STARVE_MAX times in a row.
    fu_win       = arb_en & fu_req & ~fu_block & (starved | ~mau_req);
    mau_win      = arb_en & mau_req & ~fu_win;
    starve_cnt_d = starve_cnt_q;
    if (fu_win)
      starve_cnt_d = '0;
    else if (mau_win && fu_req && !starved)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch (reads) and the
// memory-access unit (reads/writes). One transaction outstanding at a time,
// registered outputs, timeout abort with a sticky error flag, and dropping of
// fetch results made stale by a flush.
//   i_fu_*  / o_fu_*  : fetch request/grant and instruction return
//   i_mau_* / o_mau_* : data request/grant and read data / write completion
//   o_mem_* / i_mem_* : memory port, request held until i_mem_ack
//   o_timeout_err     : set when a transaction is aborted, cleared by rst only
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fu_req,
  input  logic [AW-1:0] i_fu_addr,
  input  logic          i_fu_flush,
  output logic          o_fu_gnt,
  output logic          o_fu_valid,
  output logic [AW-1:0] o_fu_inst,
  output logic [AW-1:0] o_fu_addr,
  input  logic          i_mau_req,
  input  logic          i_mau_we,
  input  logic [AW-1:0] i_mau_addr,
  input  logic [AW-1:0] i_mau_wdata,
  input  logic [1:0]    i_mau_len,
  output logic          o_mau_gnt,
  output logic          o_mau_valid,
  output logic [AW-1:0] o_mau_rdata,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [AW-1:0] o_mem_wdata,
  output logic [1:0]    o_mem_len,
  input  logic          i_mem_ack,
  input  logic [AW-1:0] i_mem_rdata,
  output logic          o_timeout_err
);

  localparam int TW = $clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          drop_q, drop_d;
  logic          fu_gnt_q, fu_gnt_d, mau_gnt_q, mau_gnt_d;
  logic          fu_valid_q, fu_valid_d, mau_valid_q, mau_valid_d;
  logic [AW-1:0] fu_inst_q, fu_inst_d, fu_addr_q, fu_addr_d;
  logic [AW-1:0] mau_rdata_q, mau_rdata_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_len_q, mem_len_d;
  logic          err_q, err_d;
  logic          fu_win, mau_win;

  mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (state_q == IDLE),
    .fu_req   (i_fu_req),
    .fu_block (i_fu_flush),
    .mau_req  (i_mau_req),
    .fu_win   (fu_win),
    .mau_win  (mau_win)
  );

  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    drop_d      = drop_q;
    fu_gnt_d    = 1'b0;
    mau_gnt_d   = 1'b0;
    fu_valid_d  = 1'b0;
    mau_valid_d = 1'b0;
    fu_inst_d   = fu_inst_q;
    fu_addr_d   = fu_addr_q;
    mau_rdata_d = mau_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        drop_d    = 1'b0;
        if (fu_win) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_fu_addr;
          mem_wdata_d = '0;
          mem_len_d   = LEN_W;
          fu_gnt_d    = 1'b1;
          state_d     = BUSY_I;
        end else if (mau_win) begin
          mem_req_d   = 1'b1;
          mem_we_d    = i_mau_we;
          mem_addr_d  = i_mau_addr;
          mem_wdata_d = i_mau_wdata;
          mem_len_d   = i_mau_len;
          mau_gnt_d   = 1'b1;
          state_d     = BUSY_D;
        end
      end

      BUSY_I, BUSY_D: begin
        if (state_q == BUSY_I && i_fu_flush) drop_d = 1'b1;
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          drop_d    = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_I) begin
            // A flush seen at any point of the fetch, ack cycle included, kills it.
            if (!(drop_q || i_fu_flush)) begin
              fu_valid_d = 1'b1;
              fu_inst_d  = i_mem_rdata;
              fu_addr_d  = mem_addr_q;
            end
          end else begin
            mau_valid_d = 1'b1;
            mau_rdata_d = mem_we_q ? '0 : i_mem_rdata;
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          tmo_cnt_d = '0;
          drop_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      drop_q      <= 1'b0;
      fu_gnt_q    <= 1'b0;
      mau_gnt_q   <= 1'b0;
      fu_valid_q  <= 1'b0;
      mau_valid_q <= 1'b0;
      fu_inst_q   <= '0;
      fu_addr_q   <= '0;
      mau_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drop_q      <= drop_d;
      fu_gnt_q    <= fu_gnt_d;
      mau_gnt_q   <= mau_gnt_d;
      fu_valid_q  <= fu_valid_d;
      mau_valid_q <= mau_valid_d;
      fu_inst_q   <= fu_inst_d;
      fu_addr_q   <= fu_addr_d;
      mau_rdata_q <= mau_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      err_q       <= err_d;
    end
  end

  assign o_fu_gnt      = fu_gnt_q;
  assign o_fu_valid    = fu_valid_q;
  assign o_fu_inst     = fu_inst_q;
  assign o_fu_addr     = fu_addr_q;
  assign o_mau_gnt     = mau_gnt_q;
  assign o_mau_valid   = mau_valid_q;
  assign o_mau_rdata   = mau_rdata_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_mem_len     = mem_len_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_fu_req = 1'b0, i_fu_flush = 1'b0;
  logic [31:0] i_fu_addr = '0;
  logic        o_fu_gnt, o_fu_valid;
  logic [31:0] o_fu_inst, o_fu_addr;
  logic        i_mau_req = 1'b0, i_mau_we = 1'b0;
  logic [31:0] i_mau_addr = '0, i_mau_wdata = '0;
  logic [1:0]  i_mau_len = 2'b00;
  logic        o_mau_gnt, o_mau_valid;
  logic [31:0] o_mau_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [1:0]  o_mem_len;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64), .AW(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_fu_req(i_fu_req), .i_fu_addr(i_fu_addr), .i_fu_flush(i_fu_flush),
    .o_fu_gnt(o_fu_gnt), .o_fu_valid(o_fu_valid), .o_fu_inst(o_fu_inst), .o_fu_addr(o_fu_addr),
    .i_mau_req(i_mau_req), .i_mau_we(i_mau_we), .i_mau_addr(i_mau_addr),
    .i_mau_wdata(i_mau_wdata), .i_mau_len(i_mau_len),
    .o_mau_gnt(o_mau_gnt), .o_mau_valid(o_mau_valid), .o_mau_rdata(o_mau_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_len(o_mem_len),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_timeout_err(o_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_fu_gnt",  {31'd0, o_fu_gnt},  32'd0);
    chk("rst_err",     {31'd0, o_timeout_err}, 32'd0);
    chk("rst_addr",    o_mem_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Fetch only
    i_fu_req = 1'b1; i_fu_addr = 32'h100;
    tick();
    chk("f_gnt",   {31'd0, o_fu_gnt},  32'd1);
    chk("f_req",   {31'd0, o_mem_req}, 32'd1);
    chk("f_addr",  o_mem_addr, 32'h100);
    chk("f_we",    {31'd0, o_mem_we},  32'd0);
    i_fu_req = 1'b0;
    tick();
    chk("f_gnt_pulse", {31'd0, o_fu_gnt}, 32'd0);
    tick();
    chk("f_req_held", {31'd0, o_mem_req}, 32'd1);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h00500093;
    tick();
    i_mem_ack = 1'b0;
    chk("f_valid", {31'd0, o_fu_valid}, 32'd1);
    chk("f_inst",  o_fu_inst, 32'h00500093);
    chk("f_vaddr", o_fu_addr, 32'h100);
    chk("f_req_drop", {31'd0, o_mem_req}, 32'd0);
    tick();
    chk("f_valid_pulse", {31'd0, o_fu_valid}, 32'd0);

    // Simultaneous: data first, then fetch
    i_fu_req = 1'b1; i_fu_addr = 32'h104;
    i_mau_req = 1'b1; i_mau_we = 1'b0; i_mau_addr = 32'h2000; i_mau_len = 2'b10;
    tick();
    chk("s_mau_gnt", {31'd0, o_mau_gnt}, 32'd1);
    chk("s_fu_gnt",  {31'd0, o_fu_gnt},  32'd0);
    chk("s_addr",    o_mem_addr, 32'h2000);
    chk("s_starve1", 32'(u_dut.u_prio.starve_cnt_q), 32'd1);
    i_mau_req = 1'b0;
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h11223344;
    tick();
    i_mem_ack = 1'b0;
    chk("s_mau_valid", {31'd0, o_mau_valid}, 32'd1);
    chk("s_rdata", o_mau_rdata, 32'h11223344);
    chk("s_no_gnt_on_valid", {31'd0, o_fu_gnt}, 32'd0);
    tick();
    chk("s_fu_gnt2", {31'd0, o_fu_gnt}, 32'd1);
    chk("s_addr2", o_mem_addr, 32'h104);
    chk("s_starve0", 32'(u_dut.u_prio.starve_cnt_q), 32'd0);
    i_fu_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h00000013;
    tick();
    i_mem_ack = 1'b0;
    chk("s_fu_valid", {31'd0, o_fu_valid}, 32'd1);
    tick();

    // Starvation: 4 data wins, 5th grant to fetch
    i_fu_req = 1'b1; i_fu_addr = 32'h180;
    i_mau_req = 1'b1; i_mau_addr = 32'h2100;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk($sformatf("st_mau_gnt%0d", r), {31'd0, o_mau_gnt}, (r < 4) ? 32'd1 : 32'd0);
      chk($sformatf("st_fu_gnt%0d", r),  {31'd0, o_fu_gnt},  (r < 4) ? 32'd0 : 32'd1);
      if (r == 3) chk("st_sat", 32'(u_dut.u_prio.starve_cnt_q), 32'd4);
      i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
      tick();
      i_mem_ack = 1'b0;
    end
    chk("st_fu_valid", {31'd0, o_fu_valid}, 32'd1);
    chk("st_clr", 32'(u_dut.u_prio.starve_cnt_q), 32'd0);
    i_fu_req = 1'b0; i_mau_req = 1'b0;
    tick();

    // Flush in idle blocks fetch
    i_fu_req = 1'b1; i_fu_addr = 32'h108; i_fu_flush = 1'b1;
    tick();
    chk("fl_idle_block", {31'd0, o_fu_gnt}, 32'd0);
    chk("fl_idle_req", {31'd0, o_mem_req}, 32'd0);
    i_fu_flush = 1'b0;
    // Flush during busy drops the result
    tick();
    chk("fl_gnt", {31'd0, o_fu_gnt}, 32'd1);
    i_fu_req = 1'b0; i_fu_flush = 1'b1;
    tick();
    i_fu_flush = 1'b0;
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    tick();
    i_mem_ack = 1'b0;
    chk("fl_no_valid", {31'd0, o_fu_valid}, 32'd0);
    chk("fl_req_drop", {31'd0, o_mem_req}, 32'd0);
    i_fu_req = 1'b1; i_fu_addr = 32'h200;
    tick();
    chk("fl_gnt2", {31'd0, o_fu_gnt}, 32'd1);
    i_fu_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h00000513;
    tick();
    i_mem_ack = 1'b0;
    chk("fl_valid2", {31'd0, o_fu_valid}, 32'd1);
    chk("fl_inst2", o_fu_inst, 32'h00000513);
    chk("fl_addr2", o_fu_addr, 32'h200);
    tick();

    // Write
    i_mau_req = 1'b1; i_mau_we = 1'b1; i_mau_addr = 32'h3000;
    i_mau_wdata = 32'hCAFEF00D; i_mau_len = 2'b10;
    tick();
    chk("w_gnt",   {31'd0, o_mau_gnt}, 32'd1);
    chk("w_we",    {31'd0, o_mem_we},  32'd1);
    chk("w_addr",  o_mem_addr,  32'h3000);
    chk("w_wdata", o_mem_wdata, 32'hCAFEF00D);
    chk("w_len",   {30'd0, o_mem_len}, 32'd2);
    i_mau_req = 1'b0; i_mau_addr = 32'h9999; i_mau_wdata = 32'h12345678;
    tick();
    chk("w_addr_held",  o_mem_addr,  32'h3000);
    chk("w_wdata_held", o_mem_wdata, 32'hCAFEF00D);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h55555555;
    tick();
    i_mem_ack = 1'b0;
    chk("w_valid", {31'd0, o_mau_valid}, 32'd1);
    chk("w_rdata0", o_mau_rdata, 32'd0);
    tick();

    // Timeout
    i_fu_req = 1'b1; i_fu_addr = 32'h400;
    tick();
    chk("t_gnt", {31'd0, o_fu_gnt}, 32'd1);
    i_fu_req = 1'b0;
    begin
      int hi = 0;
      for (int i = 0; i < 63; i++) begin
        tick();
        if (o_mem_req) hi++;
      end
      chk("t_hold_cycles", 32'(hi), 32'd63);
    end
    tick();
    chk("t_req_drop", {31'd0, o_mem_req}, 32'd0);
    chk("t_err", {31'd0, o_timeout_err}, 32'd1);
    chk("t_no_valid", {31'd0, o_fu_valid}, 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
    tick();
    i_mem_ack = 1'b0;
    chk("t_late_ack", {31'd0, o_fu_valid}, 32'd0);
    chk("t_err_sticky", {31'd0, o_timeout_err}, 32'd1);

    // Reset mid-busy
    i_mau_req = 1'b1; i_mau_we = 1'b0; i_mau_addr = 32'h5000;
    tick();
    chk("r_gnt", {31'd0, o_mau_gnt}, 32'd1);
    i_mau_req = 1'b0;
    tick();
    chk("r_busy", {31'd0, o_mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("r_req_async", {31'd0, o_mem_req}, 32'd0);
    chk("r_err_clr", {31'd0, o_timeout_err}, 32'd0);
    chk("r_addr_clr", o_mem_addr, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("r_idle", {31'd0, o_mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
